accu_job_scheduler: RTL and testbench



---
 rtl/accu_job_scheduler.sv | 134 +++++++++++++
 tb/tb_accu_job_scheduler.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accu_job_scheduler.sv
// Job scheduler for the stream accumulator: queues job lengths pushed by the
// register logic and runs them one at a time on the accumulator, with a
// per-job timeout guard, completion pulses, a completed-job count and sticky errors.
module accu_job_scheduler #(
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned LEN_W   = 32,
  parameter int unsigned TIMEOUT = 65536
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [LEN_W-1:0]           cmd_length,
  input  logic                       abort,
  output logic                       accu_en,
  output logic [LEN_W-1:0]           accu_length,
  input  logic                       accu_finished,
  output logic                       job_done,
  output logic [15:0]                job_count,
  output logic                       busy,
  output logic [$clog2(QDEPTH):0]    q_level,
  output logic                       err_timeout,
  output logic                       err_zero_len
);

  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StAck, StRun, StGap, StErr} state_e;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  mem_q [QDEPTH];
  logic [PW-1:0]     rd_ptr_q, wr_ptr_q;
  logic [LW-1:0]     level_q;
  logic [TW-1:0]     tmr_q;
  logic [LEN_W-1:0]  length_q;
  logic [15:0]       count_q;
  logic              err_to_q, err_zl_q;
  logic              push, store, pop, timeout_hit;

  // Zero-length pushes are accepted (ready honoured) but never stored.
  assign push        = cmd_valid && cmd_ready && !abort;
  assign store       = push && (cmd_length != '0);
  assign pop         = (state_q == StIdle) && (level_q != '0) && !abort;
  // Last permitted cycle of ACK+RUN; leaving it unfinished is a timeout.
  assign timeout_hit = (tmr_q == TW'(TIMEOUT - 1));

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state_q <= StIdle;
    else            state_q <= state_d;
  end

  // Next-state logic; abort overrides everything
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (level_q != '0) state_d = StAck;
        StAck: begin
          if (timeout_hit)         state_d = StErr;
          else if (!accu_finished) state_d = StRun;
        end
        StRun: begin
          // A finish on the final permitted cycle still counts as success
          if (accu_finished)       state_d = StGap;
          else if (timeout_hit)    state_d = StErr;
        end
        StGap:   state_d = StIdle;
        StErr:   state_d = StErr;
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs decoded from state and queue occupancy
  always_comb begin
    accu_en      = (state_q == StAck) || (state_q == StRun);
    job_done     = (state_q == StGap);
    cmd_ready    = (level_q != LW'(QDEPTH)) && (state_q != StErr);
    busy         = (state_q != StIdle) || (level_q != '0);
    accu_length  = length_q;
    job_count    = count_q;
    q_level      = level_q;
    err_timeout  = err_to_q;
    err_zero_len = err_zl_q;
  end

  // Queue storage; no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge sys_clk) begin
    if (store) mem_q[wr_ptr_q] <= cmd_length;
  end

  // Queue pointers, job latch, timeout counter, job count and sticky errors
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      tmr_q    <= '0;
      length_q <= '0;
      count_q  <= '0;
      err_to_q <= 1'b0;
      err_zl_q <= 1'b0;
    end else if (abort) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      tmr_q    <= '0;
      count_q  <= '0;
      err_to_q <= 1'b0;
      err_zl_q <= 1'b0;
    end else begin
      if (store) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        length_q <= mem_q[rd_ptr_q];
      end
      if (store && !pop)      level_q <= level_q + 1'b1;
      else if (!store && pop) level_q <= level_q - 1'b1;

      if (pop)                                               tmr_q <= '0;
      else if ((state_q == StAck) || (state_q == StRun))     tmr_q <= tmr_q + 1'b1;

      if (push && (cmd_length == '0))                        err_zl_q <= 1'b1;
      if ((state_q == StRun) && accu_finished)               count_q  <= count_q + 1'b1;
      if ((state_d == StErr) && (state_q != StErr))          err_to_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_accu_job_scheduler.sv
// Directed bench for accu_job_scheduler with a small behavioural accumulator.
module tb_accu_job_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_length = '0;
  logic        abort = 1'b0;
  logic        accu_en;
  logic [31:0] accu_length;
  logic        fin;
  logic        job_done;
  logic [15:0] job_count;
  logic        busy;
  logic [2:0]  q_level;
  logic        err_timeout;
  logic        err_zero_len;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  accu_job_scheduler #(.QDEPTH(4), .LEN_W(32), .TIMEOUT(16)) dut (
    .sys_clk      (clk),
    .sys_rst_n    (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_length   (cmd_length),
    .abort        (abort),
    .accu_en      (accu_en),
    .accu_length  (accu_length),
    .accu_finished(fin),
    .job_done     (job_done),
    .job_count    (job_count),
    .busy         (busy),
    .q_level      (q_level),
    .err_timeout  (err_timeout),
    .err_zero_len (err_zero_len)
  );

  // Accumulator model: finished drops one cycle after enable, rises after
  // accu_length beats; hang keeps it low forever.
  logic        hang = 1'b0;
  logic        started;
  logic [31:0] beats;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || !accu_en) begin
      fin <= 1'b1; started <= 1'b0; beats <= '0;
    end else if (!started) begin
      fin <= 1'b0; started <= 1'b1; beats <= '0;
    end else if (!fin && !hang) begin
      beats <= beats + 1;
      if (beats + 1 == accu_length) fin <= 1'b1;
    end
  end

  // Monitor: job lengths, length stability, enable gaps and done pulses
  int          done_cnt = 0, viol = 0, min_gap = 1000, low_run = 0, high_run = 0, last_high = 0;
  logic        en_prev = 1'b0;
  logic [31:0] len_hold = '0;
  int          lens[$];
  always @(negedge clk) begin
    if (accu_en) begin
      if (!en_prev) begin
        lens.push_back(int'(accu_length));
        len_hold = accu_length;
        if (low_run < min_gap) min_gap = low_run;
        high_run = 0;
      end else if (accu_length != len_hold) begin
        viol++;
      end
      high_run++;
      low_run = 0;
    end else begin
      if (en_prev) last_high = high_run;
      low_run++;
    end
    if (job_done) done_cnt++;
    en_prev = accu_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] len);
    int w = 0;
    while (!cmd_ready && w < 100) begin tick(); w++; end
    if (!cmd_ready) chk("push_wait", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_length = len;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    tick();
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((busy || accu_en) && w < 400) begin tick(); w++; end
    chk("idle_reached", 32'(busy), 0);
  endtask

  task automatic wait_en();
    int w = 0;
    while (!accu_en && w < 50) begin tick(); w++; end
    chk("en_seen", 32'(accu_en), 1);
  endtask

  int d0, n0;

  initial begin
    // Reset state
    #12 chk("rst_en", 32'(accu_en), 0);
    chk("rst_len", accu_length, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(cmd_ready), 1);
    chk("rst_level", 32'(q_level), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_count", 32'(job_count), 0);
    chk("rst_errs", {30'd0, err_timeout, err_zero_len}, 0);
    chk("rst_done", 32'(job_done), 0);

    // Single job of 8 beats
    push(8);
    wait_idle();
    chk("t1_done", 32'(done_cnt), 1);
    chk("t1_count", 32'(job_count), 1);
    chk("t1_len", 32'(lens[0]), 8);
    chk("t1_en_low", 32'(accu_en), 0);

    // Fill queue: 3 is popped at once, 5,1,7,9 fill it, push of 2 stalls
    min_gap = 1000;
    push(3); push(5); push(1); push(7); push(9);
    chk("t2_full_level", 32'(q_level), 4);
    chk("t2_full_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_length = 2;
    tick();
    cmd_valid = 1'b0;
    chk("t2_stall_level", 32'(q_level), 4);
    wait_idle();
    chk("t2_done", 32'(done_cnt), 6);
    chk("t2_count", 32'(job_count), 6);
    chk("t2_njobs", 32'(lens.size()), 6);
    chk("t2_order", {lens[1][7:0], lens[2][7:0], lens[3][7:0], lens[4][7:0]}, 32'h03050107);
    chk("t2_last", 32'(lens[5]), 9);
    chk("t2_gap", 32'(min_gap), 2);
    chk("t2_level0", 32'(q_level), 0);

    // Zero-length push is dropped and flagged
    push(0);
    chk("t3_zl_err", 32'(err_zero_len), 1);
    chk("t3_zl_level", 32'(q_level), 0);
    push(2);
    wait_idle();
    chk("t3_done", 32'(done_cnt), 7);
    chk("t3_count", 32'(job_count), 7);
    chk("t3_len", 32'(lens[lens.size()-1]), 2);

    // Timeout: accumulator never finishes
    hang = 1'b1;
    push(4);
    begin
      int w = 0;
      while (!err_timeout && w < 100) begin tick(); w++; end
    end
    chk("t4_err", 32'(err_timeout), 1);
    chk("t4_en_cycles", 32'(last_high), 16);
    chk("t4_en_low", 32'(accu_en), 0);
    chk("t4_ready", 32'(cmd_ready), 0);
    cmd_valid = 1'b1; cmd_length = 5;
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("t4_ignored_level", 32'(q_level), 0);
    chk("t4_err_busy", 32'(busy), 1);
    chk("t4_no_done", 32'(done_cnt), 7);
    hang = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_abort_errs", {30'd0, err_timeout, err_zero_len}, 0);
    chk("t4_abort_count", 32'(job_count), 0);
    chk("t4_abort_ready", 32'(cmd_ready), 1);
    chk("t4_abort_busy", 32'(busy), 0);

    // Abort mid-RUN with two queued jobs; concurrent push discarded
    push(8); push(3); push(5);
    wait_en();
    tick(); tick();
    chk("t5_level_pre", 32'(q_level), 2);
    chk("t5_running", 32'(accu_en), 1);
    d0 = done_cnt; n0 = lens.size();
    abort = 1'b1; cmd_valid = 1'b1; cmd_length = 6;
    tick();
    abort = 1'b0; cmd_valid = 1'b0;
    chk("t5_en", 32'(accu_en), 0);
    chk("t5_level", 32'(q_level), 0);
    chk("t5_count", 32'(job_count), 0);
    chk("t5_busy", 32'(busy), 0);
    repeat (5) tick();
    chk("t5_no_done", 32'(done_cnt - d0), 0);
    chk("t5_no_job", 32'(lens.size() - n0), 0);
    push(4);
    wait_idle();
    chk("t5_after_count", 32'(job_count), 1);
    chk("t5_after_len", 32'(lens[lens.size()-1]), 4);
    chk("t5_after_done", 32'(done_cnt - d0), 1);

    // Asynchronous reset during RUN
    push(8); push(3);
    wait_en();
    tick(); tick();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_en", 32'(accu_en), 0);
    chk("t6_len", accu_length, 0);
    chk("t6_count", 32'(job_count), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_level", 32'(q_level), 0);
    chk("t6_ready", 32'(cmd_ready), 1);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk("t6_post_busy", 32'(busy), 0);
    chk("t6_post_en", 32'(accu_en), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
